vending_controller: RTL and testbench
=====================================

# vending_controller

Sequencing and arbitration controller for the vending datapath. Two coin acceptors share a single credit accumulator through a round-robin arbiter. Once credit reaches the price, the block runs one dispense handshake with the dispenser, and a cancel runs one refund handshake instead. It sits between the coin-acceptor front ends and the dispenser/refund mechanisms.

## Interface
- PRICE, 4: coins needed per vend; 1 ≤ PRICE ≤ 2^CREDIT_W − 1
- CREDIT_W, 3: credit register width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- io_coin0_valid  in  1  acceptor 0 offers one coin (value 1)
- io_coin0_ready  out  1  controller takes acceptor 0's coin this cycle
- io_coin1_valid  in  1  acceptor 1 offers one coin
- io_coin1_ready  out  1  controller takes acceptor 1's coin this cycle
- io_cancel  in  1  customer cancel request, sampled each cycle
- io_dispense_valid  out  1  vend request to dispenser
- io_dispense_ready  in  1  dispenser accepts vend
- io_refund_valid  out  1  refund request
- io_refund_ready  in  1  refund mechanism accepts
- io_refund_amount  out  CREDIT_W  coins to return; valid while io_refund_valid
- io_credit  out  CREDIT_W  current credit register
- io_vend_count  out  8  completed vends, wraps 255→0

## Operation
- State register has three states: ACCEPT, DISPENSE, REFUND.
- Registers: state, credit, rr_ptr (1 bit, the requester favoured next), vend_count.
- Reset values: state=ACCEPT, credit=0, rr_ptr=0, vend_count=0.
- Output values during reset: every ready and valid output is 0, io_refund_amount=0, io_credit=0, io_vend_count=0.
- ACCEPT state:
  - Coin readies are asserted only when credit < PRICE and io_cancel=0.
  - Grant when only one requester is valid: that requester.
  - Grant when both are valid: the requester selected by rr_ptr. The other requester's ready stays 0 and its coin is held off.
  - At most one ready is high per cycle. Ready never depends on the ungranted requester.
  - On a transfer (valid & ready): credit ← credit+1 and rr_ptr ← index of the other requester.
  - rr_ptr is unchanged on cycles with no transfer.
  - If credit+1 == PRICE, the next state is DISPENSE.
  - io_cancel=1 with credit>0: next state is REFUND, and no coin is accepted that cycle (cancel has priority).
  - io_cancel=1 with credit=0: ignored; state stays ACCEPT and readies stay 0 that cycle.
- DISPENSE state:
  - io_dispense_valid=1 and all coin readies are 0. Cancel is ignored.
  - valid is held until io_dispense_ready=1.
  - On the handshake: credit ← 0, vend_count ← vend_count+1 (modulo 256), next state ACCEPT.
- REFUND state:
  - io_refund_valid=1 and io_refund_amount=credit, held stable until io_refund_ready=1. Coin readies are 0.
  - On the handshake: credit ← 0, next state ACCEPT. vend_count is unchanged.
- Credit never exceeds PRICE and never wraps. No coin is accepted when credit == PRICE.
- Reset asserted mid-handshake in any state: all registers clear at once, and the pending valid drops in the same cycle. No vend or refund is counted.

## Timing
- Coin readies are combinational (Mealy) from the valids, io_cancel, state, credit and rr_ptr. There is no combinational path from any ready input.
- io_dispense_valid, io_refund_valid, io_refund_amount, io_credit and io_vend_count are functions of registered state only (Moore).
- The coin that reaches PRICE is accepted on edge n. io_dispense_valid rises in cycle n+1.
- Dispense handshake completes on edge m. In cycle m+1 io_dispense_valid=0, io_credit=0, and a coin can be accepted in that same cycle m+1.
- Cancel is sampled on edge n. io_refund_valid rises in cycle n+1.
- Dispense throughput: at minimum PRICE+1 cycles per vend with the dispenser always ready.
- Coin valids from the acceptors must stay asserted until ready. The controller never drops a granted coin.

## Test plan
- Coins on acceptor 0 only, PRICE=4, dispense_ready=1: four transfers on consecutive cycles → dispense_valid high for exactly 1 cycle in cycle 5, io_credit back to 0, io_vend_count=1.
- Both acceptors valid continuously from reset → readies alternate 0,1,0,1 (coin0 first). Credit steps 1..4, then both readies are 0 for the whole DISPENSE state.
- Credit=3 and io_cancel together with coin0_valid → coin0_ready=0, refund_valid rises the next cycle with refund_amount=3. Holding refund_ready=0 for 5 cycles keeps the amount stable. On the handshake credit=0 and vend_count is unchanged.
- io_cancel with credit=0 → no refund, state stays ACCEPT, readies 0 only in the cancel cycle.
- DISPENSE with dispense_ready low for 10 cycles and cancel pulsed → valid held 10 cycles, cancel ignored, exactly one vend counted.
- Reset asserted asynchronously mid-refund with credit=2 → refund_valid, credit and rr_ptr clear at once. 256 vends from reset → io_vend_count wraps to 0.

Source files
------------

// File: rtl/vending_controller_if.sv
// Handshake bundle between the vending controller and its coin acceptors,
// dispenser and refund mechanism. The master modport is the controller side.
interface vending_controller_if #(
  parameter int CREDIT_W = 3
);
  // valid/ready: a transfer happens on a rising edge where both are 1. A
  // producer holds valid (and its payload) stable until it sees ready.
  logic                io_coin0_valid;
  logic                io_coin0_ready;
  logic                io_coin1_valid;
  logic                io_coin1_ready;
  logic                io_cancel;
  logic                io_dispense_valid;
  logic                io_dispense_ready;
  logic                io_refund_valid;
  logic                io_refund_ready;
  logic [CREDIT_W-1:0] io_refund_amount;
  logic [CREDIT_W-1:0] io_credit;
  logic [7:0]          io_vend_count;
  logic [1:0]          dbg_state;
  logic                dbg_rr_ptr;

  modport master (
    input  io_coin0_valid, io_coin1_valid, io_cancel,
           io_dispense_ready, io_refund_ready,
    output io_coin0_ready, io_coin1_ready, io_dispense_valid,
           io_refund_valid, io_refund_amount, io_credit, io_vend_count,
           dbg_state, dbg_rr_ptr
  );

  modport slave (
    output io_coin0_valid, io_coin1_valid, io_cancel,
           io_dispense_ready, io_refund_ready,
    input  io_coin0_ready, io_coin1_ready, io_dispense_valid,
           io_refund_valid, io_refund_amount, io_credit, io_vend_count,
           dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/vending_controller.sv
// Vending controller: round-robin coin arbitration into a credit register,
// then one dispense handshake at PRICE or one refund handshake on cancel.
module vending_controller #(
  parameter int PRICE    = 4,
  parameter int CREDIT_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  vending_controller_if.master  bus
);
  typedef enum logic [1:0] {
    ACCEPT   = 2'd0,
    DISPENSE = 2'd1,
    REFUND   = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n;
  logic                rr_ptr, rr_ptr_n;
  logic [7:0]          vend_count, vend_count_n;
  logic                grant0, grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ACCEPT;
      credit     <= '0;
      rr_ptr     <= 1'b0;
      vend_count <= '0;
    end else begin
      state      <= state_n;
      credit     <= credit_n;
      rr_ptr     <= rr_ptr_n;
      vend_count <= vend_count_n;
    end
  end

  always_comb begin
    state_n             = state;
    credit_n            = credit;
    rr_ptr_n            = rr_ptr;
    vend_count_n        = vend_count;
    grant0              = 1'b0;
    grant1              = 1'b0;
    bus.io_coin0_ready  = 1'b0;
    bus.io_coin1_ready  = 1'b0;
    case (state)
      ACCEPT: begin
        if (bus.io_cancel) begin
          // A cancel with no credit is simply dropped for this cycle.
          if (credit != '0) state_n = REFUND;
        end else if (credit < PRICE_C) begin
          grant0 = bus.io_coin0_valid && (!bus.io_coin1_valid || !rr_ptr);
          grant1 = bus.io_coin1_valid && (!bus.io_coin0_valid ||  rr_ptr);
          bus.io_coin0_ready = grant0 && !reset;
          bus.io_coin1_ready = grant1 && !reset;
          if (grant0 || grant1) begin
            credit_n = credit + ONE_C;
            rr_ptr_n = grant0;
            if (credit + ONE_C == PRICE_C) state_n = DISPENSE;
          end
        end
      end
      DISPENSE: begin
        if (bus.io_dispense_ready) begin
          credit_n     = '0;
          vend_count_n = vend_count + 8'd1;
          state_n      = ACCEPT;
        end
      end
      REFUND: begin
        if (bus.io_refund_ready) begin
          credit_n = '0;
          state_n  = ACCEPT;
        end
      end
      default: state_n = ACCEPT;
    endcase
  end

  assign bus.io_dispense_valid = (state == DISPENSE);
  assign bus.io_refund_valid   = (state == REFUND);
  assign bus.io_refund_amount  = (state == REFUND) ? credit : '0;
  assign bus.io_credit         = credit;
  assign bus.io_vend_count     = vend_count;
  assign bus.dbg_state         = state;
  assign bus.dbg_rr_ptr        = rr_ptr;
endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller: arbitration, vend, refund, cancel
// corner cases, asynchronous reset and vend counter wrap.
module tb_vending_controller;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  vending_controller_if #(.CREDIT_W(3)) bus ();

  vending_controller #(.PRICE(4), .CREDIT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset = 1'b1;
    bus.io_coin0_valid    = 1'b1;
    bus.io_coin1_valid    = 1'b1;
    bus.io_cancel         = 1'b0;
    bus.io_dispense_ready = 1'b0;
    bus.io_refund_ready   = 1'b0;

    // reset values, with both coins offered
    #1;
    chk("rst_ready0", 32'(bus.io_coin0_ready), 0);
    chk("rst_ready1", 32'(bus.io_coin1_ready), 0);
    chk("rst_disp_valid", 32'(bus.io_dispense_valid), 0);
    chk("rst_ref_valid", 32'(bus.io_refund_valid), 0);
    chk("rst_ref_amount", 32'(bus.io_refund_amount), 0);
    chk("rst_credit", 32'(bus.io_credit), 0);
    chk("rst_vend_count", 32'(bus.io_vend_count), 0);
    bus.io_coin0_valid = 1'b0;
    bus.io_coin1_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // acceptor 0 only, dispenser always ready
    bus.io_coin0_valid    = 1'b1;
    bus.io_dispense_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t1_ready0", 32'(bus.io_coin0_ready), 1);
      chk("t1_credit", 32'(bus.io_credit), 32'(i));
      chk("t1_disp_low", 32'(bus.io_dispense_valid), 0);
      tick();
      if (i == 3) bus.io_coin0_valid = 1'b0;
    end
    #1;
    chk("t1_disp_valid", 32'(bus.io_dispense_valid), 1);
    chk("t1_credit_full", 32'(bus.io_credit), 4);
    tick();
    chk("t1_disp_drop", 32'(bus.io_dispense_valid), 0);
    chk("t1_credit_clr", 32'(bus.io_credit), 0);
    chk("t1_vend_count", 32'(bus.io_vend_count), 1);
    chk("t1_rr_ptr", 32'(bus.dbg_rr_ptr), 1);

    // mid-cycle reset, then both acceptors valid continuously
    reset = 1'b1;
    #1;
    chk("t2_rst_vc", 32'(bus.io_vend_count), 0);
    chk("t2_rst_rr", 32'(bus.dbg_rr_ptr), 0);
    reset = 1'b0;
    bus.io_coin0_valid    = 1'b1;
    bus.io_coin1_valid    = 1'b1;
    bus.io_dispense_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_ready0", 32'(bus.io_coin0_ready), (i % 2 == 0) ? 1 : 0);
      chk("t2_ready1", 32'(bus.io_coin1_ready), (i % 2 == 1) ? 1 : 0);
      chk("t2_credit", 32'(bus.io_credit), 32'(i));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_disp_ready0", 32'(bus.io_coin0_ready), 0);
      chk("t2_disp_ready1", 32'(bus.io_coin1_ready), 0);
      chk("t2_disp_valid", 32'(bus.io_dispense_valid), 1);
      tick();
    end
    bus.io_dispense_ready = 1'b1;
    tick();
    bus.io_dispense_ready = 1'b0;
    #1;
    chk("t2_post_disp", 32'(bus.io_dispense_valid), 0);
    chk("t2_post_credit", 32'(bus.io_credit), 0);
    chk("t2_post_ready0", 32'(bus.io_coin0_ready), 1);
    chk("t2_post_ready1", 32'(bus.io_coin1_ready), 0);
    tick();
    bus.io_coin1_valid = 1'b0;
    #1;
    chk("t3_solo_ready0", 32'(bus.io_coin0_ready), 1);
    tick();
    tick();
    chk("t3_credit3", 32'(bus.io_credit), 3);

    // cancel at credit 3 while coin 0 is offered
    bus.io_cancel = 1'b1;
    #1;
    chk("t3_cancel_ready0", 32'(bus.io_coin0_ready), 0);
    tick();
    bus.io_cancel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_ref_valid", 32'(bus.io_refund_valid), 1);
      chk("t3_ref_amount", 32'(bus.io_refund_amount), 3);
      chk("t3_ref_ready0", 32'(bus.io_coin0_ready), 0);
      tick();
    end
    bus.io_refund_ready = 1'b1;
    tick();
    bus.io_refund_ready = 1'b0;
    chk("t3_ref_drop", 32'(bus.io_refund_valid), 0);
    chk("t3_ref_credit", 32'(bus.io_credit), 0);
    chk("t3_ref_vc", 32'(bus.io_vend_count), 1);

    // cancel with zero credit is ignored
    bus.io_cancel = 1'b1;
    #1;
    chk("t4_ready0", 32'(bus.io_coin0_ready), 0);
    tick();
    bus.io_cancel = 1'b0;
    #1;
    chk("t4_state", 32'(bus.dbg_state), 0);
    chk("t4_ref_valid", 32'(bus.io_refund_valid), 0);
    chk("t4_ready0_back", 32'(bus.io_coin0_ready), 1);
    tick();
    chk("t4_credit", 32'(bus.io_credit), 1);

    // stalled dispenser with cancel pulses
    tick();
    tick();
    tick();
    bus.io_coin0_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.io_cancel = (i == 3 || i == 4);
      #1;
      chk("t5_disp_valid", 32'(bus.io_dispense_valid), 1);
      chk("t5_ref_valid", 32'(bus.io_refund_valid), 0);
      tick();
    end
    bus.io_cancel         = 1'b0;
    bus.io_dispense_ready = 1'b1;
    tick();
    bus.io_dispense_ready = 1'b0;
    chk("t5_vc", 32'(bus.io_vend_count), 2);
    chk("t5_state", 32'(bus.dbg_state), 0);
    chk("t5_credit", 32'(bus.io_credit), 0);

    // asynchronous reset in the middle of a refund of 2
    bus.io_coin0_valid = 1'b1;
    tick();
    tick();
    bus.io_coin0_valid = 1'b0;
    bus.io_cancel      = 1'b1;
    tick();
    bus.io_cancel = 1'b0;
    chk("t6_ref_amount", 32'(bus.io_refund_amount), 2);
    chk("t6_rr_before", 32'(bus.dbg_rr_ptr), 1);
    reset = 1'b1;
    #1;
    chk("t6_ref_valid", 32'(bus.io_refund_valid), 0);
    chk("t6_credit", 32'(bus.io_credit), 0);
    chk("t6_rr", 32'(bus.dbg_rr_ptr), 0);
    chk("t6_vc", 32'(bus.io_vend_count), 0);
    chk("t6_state", 32'(bus.dbg_state), 0);
    reset = 1'b0;
    tick();

    // 256 vends at full throughput: five cycles each
    bus.io_coin0_valid    = 1'b1;
    bus.io_dispense_ready = 1'b1;
    for (int v = 0; v < 255; v++) begin
      for (int c = 0; c < 5; c++) tick();
    end
    chk("t7_vc255", 32'(bus.io_vend_count), 255);
    for (int c = 0; c < 5; c++) tick();
    chk("t7_vc_wrap", 32'(bus.io_vend_count), 0);
    chk("t7_credit", 32'(bus.io_credit), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
